// File: rtl/ste_arb_pkg.sv
// ---------------------------------------------------------------------------
// ste_arb_pkg
// Shared definitions for the ST RAM arbiter slice.
//   owner_t        : encoding of the current slot owner (also driven on the
//                    arbiter's 'owner' output port)
//   SLOT_A_START   : frame count value that opens slot A (video/DMA/refresh)
//   SLOT_B_START   : frame count value that opens slot B (CPU/DMA)
//   CS_LEN         : number of clocks the RAM strobe stays high in a slot
//   ACK_OFS        : slot offset at which the data-valid/acknowledge appears
//   REF_TICK_FCNT  : frame count value on whose arrival the refresh timer ticks
//   isDataOwner()  : true for owners that perform a real RAM data cycle
// ---------------------------------------------------------------------------
package ste_arb_pkg;

    typedef enum logic [2:0] {
        OWN_NONE = 3'd0,
        OWN_VID  = 3'd1,
        OWN_DMA  = 3'd2,
        OWN_REF  = 3'd3,
        OWN_CPU  = 3'd4
    } owner_t;

    localparam logic [3:0] SLOT_A_START  = 4'd0;
    localparam logic [3:0] SLOT_B_START  = 4'd8;
    localparam logic [2:0] CS_LEN        = 3'd2;
    localparam logic [2:0] ACK_OFS       = 3'd5;
    localparam logic [3:0] REF_TICK_FCNT = 4'd15;

    // Video, DMA and CPU slots strobe ram_cs; refresh strobes ram_ref instead.
    function automatic logic isDataOwner(input owner_t own);
        return (own == OWN_VID) || (own == OWN_DMA) || (own == OWN_CPU);
    endfunction

endpackage

// File: rtl/ste_refresh_timer.sv
// ---------------------------------------------------------------------------
// ste_refresh_timer
// Counts frames and accumulates pending refresh requests for the arbiter.
// Every REFRESH_INTERVAL frame ticks one more refresh becomes pending; the
// pending count saturates at 3 and is consumed one per refresh grant.
//
// Ports:
//   clk32        in   system clock
//   reset        in   asynchronous reset, active-high
//   i_frameTick  in   one-clock pulse, once per 16-clock frame
//   i_grant      in   one-clock pulse when the arbiter grants a refresh slot
//   o_refPend    out  number of refreshes owed (0..3)
// ---------------------------------------------------------------------------
module ste_refresh_timer
    import ste_arb_pkg::*;
#(
    parameter int REFRESH_INTERVAL = 31
) (
    input  logic       clk32,
    input  logic       reset,
    input  logic       i_frameTick,
    input  logic       i_grant,
    output logic [1:0] o_refPend
);

    localparam int TW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam logic [TW-1:0] LAST = TW'(REFRESH_INTERVAL - 1);

    logic [TW-1:0] r_timer;
    logic [1:0]    r_refPend;
    logic          w_due;

    assign w_due     = i_frameTick && (r_timer == LAST);
    assign o_refPend = r_refPend;

    // Frame counter: runs 0..REFRESH_INTERVAL-1 and wraps, one step per frame.
    always_ff @(posedge clk32 or posedge reset) begin
        if (reset) begin
            r_timer <= '0;
        end else if (i_frameTick) begin
            if (r_timer == LAST) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + 1'b1;
            end
        end
    end

    // Pending count: a new refresh and a grant on the same edge cancel out.
    always_ff @(posedge clk32 or posedge reset) begin
        if (reset) begin
            r_refPend <= 2'd0;
        end else if (w_due && !i_grant) begin
            if (r_refPend != 2'd3) begin
                r_refPend <= r_refPend + 2'd1;
            end
        end else if (!w_due && i_grant) begin
            if (r_refPend != 2'd0) begin
                r_refPend <= r_refPend - 2'd1;
            end
        end
    end

endmodule

// File: rtl/ste_ram_arbiter.sv
// ---------------------------------------------------------------------------
// ste_ram_arbiter
// Time-division scheduler for the shared ST RAM port. Every 16-clock frame is
// split into slot A (fcnt 0..7: video > urgent refresh > DMA > refresh) and
// slot B (fcnt 8..15: CPU > DMA). The owner is chosen on the clock edge that
// enters the slot and holds for the whole slot. The owner's address and
// controls are captured on that same edge and presented to the RAM during
// slot offsets 0 and 1; data-valid / acknowledge appears at offset 5.
//
// Optional build macro: ARB_TURBO_EN
//   defined   : the CPU may take an otherwise idle slot A when 'turbo' is high
//   undefined : 'turbo' is ignored, the CPU is served in slot B only
//
// Ports:
//   clk32, reset                          clock, async active-high reset
//   cpu_req/addr/we/ds                    CPU bus cycle request
//   vid_req/addr                          shifter word fetch
//   dma_req/addr/we                       DMA word transfer
//   turbo                                 CPU may use idle slot A
//   ram_a/cs/we/ds/ref                    RAM controller port
//   owner                                 current slot owner (owner_t)
//   cpu_dtack, vid_ack, dma_ack           per-requester acknowledges
//   bus_free                              current slot is unowned
// ---------------------------------------------------------------------------
module ste_ram_arbiter
    import ste_arb_pkg::*;
#(
    parameter int ADDR_W           = 23,
    parameter int REFRESH_INTERVAL = 31
) (
    input  logic              clk32,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_we,
    input  logic [1:0]        cpu_ds,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    input  logic              dma_req,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic              dma_we,
    input  logic              turbo,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_cs,
    output logic              ram_we,
    output logic [1:0]        ram_ds,
    output logic              ram_ref,
    output logic [2:0]        owner,
    output logic              cpu_dtack,
    output logic              vid_ack,
    output logic              dma_ack,
    output logic              bus_free
);

    logic [3:0]        r_fcnt;
    logic [3:0]        w_fcntNext;
    logic [2:0]        w_k;
    logic              w_slotAStart;
    logic              w_slotBStart;
    logic              w_frameTick;
    logic              w_refGrant;
    logic [1:0]        w_refPend;
    logic              w_cpuEligible;
    logic              w_turboTake;
    logic              w_csWindow;
    owner_t            r_owner;
    owner_t            w_ownerNext;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [1:0]        r_ds;
    logic              r_dtack;

    assign w_fcntNext   = r_fcnt + 4'd1;
    assign w_k          = r_fcnt[2:0];
    assign w_slotAStart = (w_fcntNext == SLOT_A_START);
    assign w_slotBStart = (w_fcntNext == SLOT_B_START);
    assign w_frameTick  = (w_fcntNext == REF_TICK_FCNT);
    assign w_refGrant   = w_slotAStart && (w_ownerNext == OWN_REF);

`ifdef ARB_TURBO_EN
    // Set once the CPU has been served through a turbo slot A; the CPU must
    // drop cpu_req before it can be granted again, so one bus cycle is never
    // executed twice.
    logic r_turboServed;

    assign w_cpuEligible = cpu_req && !r_turboServed;
    assign w_turboTake   = turbo && !vid_req && !dma_req &&
                           (w_refPend != 2'd3) && w_cpuEligible;

    always_ff @(posedge clk32 or posedge reset) begin
        if (reset) begin
            r_turboServed <= 1'b0;
        end else if (w_slotAStart && w_turboTake) begin
            r_turboServed <= 1'b1;
        end else if (!cpu_req) begin
            r_turboServed <= 1'b0;
        end
    end
`else
    logic w_unusedTurbo;

    assign w_unusedTurbo = turbo;
    assign w_cpuEligible = cpu_req;
    assign w_turboTake   = 1'b0;
`endif

    ste_refresh_timer #(
        .REFRESH_INTERVAL(REFRESH_INTERVAL)
    ) u_refresh (
        .clk32      (clk32),
        .reset      (reset),
        .i_frameTick(w_frameTick),
        .i_grant    (w_refGrant),
        .o_refPend  (w_refPend)
    );

    // Free-running frame position; slot offsets are its low three bits.
    always_ff @(posedge clk32 or posedge reset) begin
        if (reset) begin
            r_fcnt <= 4'd0;
        end else begin
            r_fcnt <= w_fcntNext;
        end
    end

    // Owner state register: only changes on the edge that opens a slot.
    always_ff @(posedge clk32 or posedge reset) begin
        if (reset) begin
            r_owner <= OWN_NONE;
        end else begin
            r_owner <= w_ownerNext;
        end
    end

    // Owner selection for the slot that begins on the coming edge.
    always_comb begin
        w_ownerNext = r_owner;
        if (w_slotAStart) begin
            if (w_turboTake) begin
                w_ownerNext = OWN_CPU;
            end else if (vid_req) begin
                w_ownerNext = OWN_VID;
            end else if (w_refPend == 2'd3) begin
                w_ownerNext = OWN_REF;
            end else if (dma_req) begin
                w_ownerNext = OWN_DMA;
            end else if (w_refPend != 2'd0) begin
                w_ownerNext = OWN_REF;
            end else begin
                w_ownerNext = OWN_NONE;
            end
        end else if (w_slotBStart) begin
            if (w_cpuEligible) begin
                w_ownerNext = OWN_CPU;
            end else if (dma_req) begin
                w_ownerNext = OWN_DMA;
            end else begin
                w_ownerNext = OWN_NONE;
            end
        end
    end

    // Capture the new owner's address and controls at slot start so a
    // requester changing its inputs mid-slot cannot disturb the RAM cycle.
    // An idle or refresh slot leaves the address untouched.
    always_ff @(posedge clk32 or posedge reset) begin
        if (reset) begin
            r_addr <= '0;
            r_we   <= 1'b0;
            r_ds   <= 2'b00;
        end else if (w_slotAStart || w_slotBStart) begin
            case (w_ownerNext)
                OWN_CPU: begin
                    r_addr <= cpu_addr;
                    r_we   <= cpu_we;
                    r_ds   <= cpu_ds;
                end
                OWN_VID: begin
                    r_addr <= vid_addr;
                    r_we   <= 1'b0;
                    r_ds   <= 2'b11;
                end
                OWN_DMA: begin
                    r_addr <= dma_addr;
                    r_we   <= dma_we;
                    r_ds   <= 2'b11;
                end
                OWN_REF: begin
                    r_we   <= 1'b0;
                    r_ds   <= 2'b11;
                end
                default: begin
                end
            endcase
        end
    end

    // CPU acknowledge: raised entering offset 5 of a CPU slot, then held
    // until the CPU releases its request (68000-style handshake).
    always_ff @(posedge clk32 or posedge reset) begin
        if (reset) begin
            r_dtack <= 1'b0;
        end else if ((r_owner == OWN_CPU) && (w_fcntNext[2:0] == ACK_OFS)) begin
            r_dtack <= 1'b1;
        end else if (!cpu_req) begin
            r_dtack <= 1'b0;
        end
    end

    // RAM strobes and one-clock acknowledges decoded from owner and offset.
    always_comb begin
        w_csWindow = (w_k < CS_LEN);
        ram_cs     = 1'b0;
        ram_ref    = 1'b0;
        ram_we     = 1'b0;
        ram_ds     = 2'b00;
        vid_ack    = 1'b0;
        dma_ack    = 1'b0;
        if (w_csWindow) begin
            if (isDataOwner(r_owner)) begin
                ram_cs = 1'b1;
                ram_we = r_we;
                ram_ds = r_ds;
            end else if (r_owner == OWN_REF) begin
                ram_ref = 1'b1;
                ram_ds  = r_ds;
            end
        end
        if (w_k == ACK_OFS) begin
            vid_ack = (r_owner == OWN_VID);
            dma_ack = (r_owner == OWN_DMA);
        end
    end

    assign ram_a     = r_addr;
    assign owner     = r_owner;
    assign cpu_dtack = r_dtack;
    assign bus_free  = (r_owner == OWN_NONE);

endmodule

// File: tb/tb_ste_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ste_ram_arbiter
// Directed bench for ste_ram_arbiter. A bench-side cycle counter (cleared by
// reset) gives the expected frame position; expected values are written out
// by hand per scenario.
// ---------------------------------------------------------------------------
module tb_ste_ram_arbiter;

    localparam int ADDR_W = 23;

    logic              clk32 = 1'b0;
    logic              reset = 1'b1;
    logic              cpu_req, cpu_we, vid_req, dma_req, dma_we, turbo;
    logic [ADDR_W-1:0] cpu_addr, vid_addr, dma_addr;
    logic [1:0]        cpu_ds;
    logic [ADDR_W-1:0] ram_a;
    logic              ram_cs, ram_we, ram_ref, cpu_dtack, vid_ack, dma_ack, bus_free;
    logic [1:0]        ram_ds;
    logic [2:0]        owner;

    int totalCount = 0;
    int badCount   = 0;
    int tbCnt      = 0;

    ste_ram_arbiter #(
        .ADDR_W(ADDR_W),
        .REFRESH_INTERVAL(31)
    ) dut (
        .clk32    (clk32),
        .reset    (reset),
        .cpu_req  (cpu_req),
        .cpu_addr (cpu_addr),
        .cpu_we   (cpu_we),
        .cpu_ds   (cpu_ds),
        .vid_req  (vid_req),
        .vid_addr (vid_addr),
        .dma_req  (dma_req),
        .dma_addr (dma_addr),
        .dma_we   (dma_we),
        .turbo    (turbo),
        .ram_a    (ram_a),
        .ram_cs   (ram_cs),
        .ram_we   (ram_we),
        .ram_ds   (ram_ds),
        .ram_ref  (ram_ref),
        .owner    (owner),
        .cpu_dtack(cpu_dtack),
        .vid_ack  (vid_ack),
        .dma_ack  (dma_ack),
        .bus_free (bus_free)
    );

    // 32 MHz-style clock, 10 ns period in bench time.
    always #5 clk32 = ~clk32;

    // Bench view of the frame position: clocks since reset release.
    always @(posedge clk32 or posedge reset) begin
        if (reset) begin
            tbCnt <= 0;
        end else begin
            tbCnt <= tbCnt + 1;
        end
    end

    // Hard stop in case something above never returns.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        totalCount++;
        if (got !== exp) begin
            badCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic cReq, input logic [22:0] cAddr, input logic cWe,
                                 input logic [1:0] cDs, input logic vReq, input logic [22:0] vAddr,
                                 input logic dReq, input logic [22:0] dAddr, input logic dWe,
                                 input logic tIn);
        cpu_req  = cReq;
        cpu_addr = cAddr;
        cpu_we   = cWe;
        cpu_ds   = cDs;
        vid_req  = vReq;
        vid_addr = vAddr;
        dma_req  = dReq;
        dma_addr = dAddr;
        dma_we   = dWe;
        turbo    = tIn;
    endtask

    task automatic applyIdle();
        applyStimulus(1'b0, 23'h0, 1'b0, 2'b00, 1'b0, 23'h0, 1'b0, 23'h0, 1'b0, 1'b0);
    endtask

    // Advance to the falling edge at which the bench counter equals target.
    task automatic waitCnt(input int target);
        for (int i = 0; i < 4000 && tbCnt != target; i++) begin
            @(negedge clk32);
        end
        if (tbCnt != target) begin
            checkOutput("waitCnt", 32'(tbCnt), 32'(target));
        end
    endtask

    // Leaves the bench at a falling edge with reset just released (count 0).
    task automatic doReset();
        @(negedge clk32);
        reset = 1'b1;
        repeat (2) @(negedge clk32);
        reset = 1'b0;
    endtask

    initial begin
        applyIdle();

        // Reset state.
        repeat (3) @(negedge clk32);
        checkOutput("rst ram_a", 32'(ram_a), 32'h0);
        checkOutput("rst ram_cs", 32'(ram_cs), 0);
        checkOutput("rst ram_we", 32'(ram_we), 0);
        checkOutput("rst ram_ds", 32'(ram_ds), 0);
        checkOutput("rst ram_ref", 32'(ram_ref), 0);
        checkOutput("rst owner", 32'(owner), 0);
        checkOutput("rst dtack", 32'(cpu_dtack), 0);
        checkOutput("rst acks", 32'({vid_ack, dma_ack}), 0);
        checkOutput("rst bus_free", 32'(bus_free), 1);
        reset = 1'b0;

        // CPU read of byte 0x001000 (word 0x000800) served in slot B.
        doReset();
        waitCnt(3);
        applyStimulus(1'b1, 23'h000800, 1'b0, 2'b11, 1'b0, 23'h0, 1'b0, 23'h0, 1'b0, 1'b0);
        waitCnt(7);
        checkOutput("cpu pre owner", 32'(owner), 0);
        waitCnt(8);
        checkOutput("cpu owner", 32'(owner), 4);
        checkOutput("cpu cs k0", 32'(ram_cs), 1);
        checkOutput("cpu ram_a", 32'(ram_a), 32'h800);
        checkOutput("cpu we", 32'(ram_we), 0);
        checkOutput("cpu ds", 32'(ram_ds), 3);
        checkOutput("cpu bus_free", 32'(bus_free), 0);
        waitCnt(9);
        checkOutput("cpu cs k1", 32'(ram_cs), 1);
        waitCnt(10);
        checkOutput("cpu cs k2", 32'(ram_cs), 0);
        waitCnt(12);
        checkOutput("cpu dtack k4", 32'(cpu_dtack), 0);
        waitCnt(13);
        checkOutput("cpu dtack k5", 32'(cpu_dtack), 1);
        applyIdle();
        waitCnt(14);
        checkOutput("cpu dtack drop", 32'(cpu_dtack), 0);
        waitCnt(16);
        checkOutput("idle owner", 32'(owner), 0);
        checkOutput("idle bus_free", 32'(bus_free), 1);
        checkOutput("idle ram_a hold", 32'(ram_a), 32'h800);
        checkOutput("idle cs", 32'(ram_cs), 0);

        // Video and DMA together: video takes slot A, DMA the next slot B.
        doReset();
        waitCnt(10);
        applyStimulus(1'b0, 23'h0, 1'b0, 2'b00, 1'b1, 23'h000100, 1'b1, 23'h000200, 1'b0, 1'b0);
        waitCnt(16);
        checkOutput("vid owner", 32'(owner), 1);
        checkOutput("vid cs", 32'(ram_cs), 1);
        checkOutput("vid ram_a", 32'(ram_a), 32'h100);
        checkOutput("vid ds", 32'(ram_ds), 3);
        checkOutput("vid we", 32'(ram_we), 0);
        waitCnt(20);
        checkOutput("vid ack k4", 32'(vid_ack), 0);
        waitCnt(21);
        checkOutput("vid ack k5", 32'(vid_ack), 1);
        checkOutput("vid dma_ack k5", 32'(dma_ack), 0);
        vid_req = 1'b0;
        waitCnt(22);
        checkOutput("vid ack k6", 32'(vid_ack), 0);
        waitCnt(24);
        checkOutput("dma owner", 32'(owner), 2);
        checkOutput("dma ram_a", 32'(ram_a), 32'h200);
        checkOutput("dma cs", 32'(ram_cs), 1);
        waitCnt(29);
        checkOutput("dma ack k5", 32'(dma_ack), 1);
        dma_req = 1'b0;
        waitCnt(30);
        checkOutput("dma ack k6", 32'(dma_ack), 0);
        waitCnt(32);
        checkOutput("dma done owner", 32'(owner), 0);

        // Idle for 31 frames: refresh in slot A of frame 31.
        applyIdle();
        doReset();
        waitCnt(495);
        checkOutput("ref pre owner", 32'(owner), 0);
        checkOutput("ref pre strobe", 32'(ram_ref), 0);
        waitCnt(496);
        checkOutput("ref owner", 32'(owner), 3);
        checkOutput("ref strobe k0", 32'(ram_ref), 1);
        checkOutput("ref cs", 32'(ram_cs), 0);
        checkOutput("ref ds", 32'(ram_ds), 3);
        checkOutput("ref we", 32'(ram_we), 0);
        checkOutput("ref bus_free", 32'(bus_free), 0);
        waitCnt(497);
        checkOutput("ref strobe k1", 32'(ram_ref), 1);
        waitCnt(498);
        checkOutput("ref strobe k2", 32'(ram_ref), 0);
        waitCnt(512);
        checkOutput("ref consumed", 32'(owner), 0);

        // Continuous video for 93 frames: refresh debt saturates at 3.
        applyStimulus(1'b0, 23'h0, 1'b0, 2'b00, 1'b1, 23'h000300, 1'b0, 23'h0, 1'b0, 1'b0);
        doReset();
        waitCnt(1488);
        checkOutput("sat vid owner", 32'(owner), 1);
        checkOutput("sat no ref", 32'(ram_ref), 0);
        waitCnt(1490);
        applyStimulus(1'b0, 23'h0, 1'b0, 2'b00, 1'b0, 23'h000300, 1'b1, 23'h000044, 1'b0, 1'b0);
        waitCnt(1496);
        checkOutput("sat dma slotB", 32'(owner), 2);
        waitCnt(1504);
        checkOutput("sat urgent ref", 32'(owner), 3);
        checkOutput("sat ref strobe", 32'(ram_ref), 1);
        waitCnt(1512);
        checkOutput("sat dma slotB2", 32'(owner), 2);
        waitCnt(1520);
        checkOutput("sat dma over ref", 32'(owner), 2);
        waitCnt(1521);
        dma_req = 1'b0;
        waitCnt(1536);
        checkOutput("sat ref pend2", 32'(owner), 3);

        // Reset in the middle of a CPU write with UDS low / LDS high.
        applyIdle();
        doReset();
        waitCnt(3);
        applyStimulus(1'b1, 23'h000123, 1'b1, 2'b01, 1'b0, 23'h0, 1'b0, 23'h0, 1'b0, 1'b0);
        waitCnt(8);
        checkOutput("wr owner", 32'(owner), 4);
        checkOutput("wr we", 32'(ram_we), 1);
        checkOutput("wr ds", 32'(ram_ds), 1);
        checkOutput("wr ram_a", 32'(ram_a), 32'h123);
        waitCnt(9);
        checkOutput("wr we k1", 32'(ram_we), 1);
        reset = 1'b1;
        #1;
        checkOutput("midrst cs", 32'(ram_cs), 0);
        checkOutput("midrst we", 32'(ram_we), 0);
        checkOutput("midrst owner", 32'(owner), 0);
        checkOutput("midrst bus_free", 32'(bus_free), 1);
        repeat (2) @(negedge clk32);
        checkOutput("midrst dtack", 32'(cpu_dtack), 0);
        reset = 1'b0;
        waitCnt(5);
        checkOutput("postrst no dtack", 32'(cpu_dtack), 0);
        waitCnt(8);
        checkOutput("postrst owner", 32'(owner), 4);
        checkOutput("postrst cs", 32'(ram_cs), 1);
        waitCnt(13);
        checkOutput("postrst dtack", 32'(cpu_dtack), 1);
        applyStimulus(1'b0, 23'h0, 1'b0, 2'b00, 1'b0, 23'h0, 1'b1, 23'h000055, 1'b1, 1'b0);
        waitCnt(16);
        checkOutput("dmawr owner", 32'(owner), 2);
        checkOutput("dmawr we", 32'(ram_we), 1);
        checkOutput("dmawr ds", 32'(ram_ds), 3);
        checkOutput("dmawr ram_a", 32'(ram_a), 32'h55);

        // Turbo request with only the CPU pending at slot A.
        applyIdle();
        doReset();
        waitCnt(10);
        applyStimulus(1'b1, 23'h000077, 1'b0, 2'b11, 1'b0, 23'h0, 1'b0, 23'h0, 1'b0, 1'b1);
`ifdef ARB_TURBO_EN
        waitCnt(16);
        checkOutput("turbo owner A", 32'(owner), 4);
        checkOutput("turbo cs", 32'(ram_cs), 1);
        waitCnt(21);
        checkOutput("turbo dtack", 32'(cpu_dtack), 1);
        cpu_req = 1'b0;
        waitCnt(22);
        checkOutput("turbo dtack drop", 32'(cpu_dtack), 0);
        waitCnt(24);
        checkOutput("turbo slotB idle", 32'(owner), 0);
`else
        waitCnt(16);
        checkOutput("noturbo owner A", 32'(owner), 0);
        checkOutput("noturbo bus_free", 32'(bus_free), 1);
        waitCnt(24);
        checkOutput("noturbo owner B", 32'(owner), 4);
        waitCnt(29);
        checkOutput("noturbo dtack", 32'(cpu_dtack), 1);
        cpu_req = 1'b0;
`endif

        // Turbo low: CPU waits for slot B in either build.
        applyIdle();
        doReset();
        waitCnt(10);
        applyStimulus(1'b1, 23'h000078, 1'b0, 2'b11, 1'b0, 23'h0, 1'b0, 23'h0, 1'b0, 1'b0);
        waitCnt(16);
        checkOutput("turbo0 owner A", 32'(owner), 0);
        waitCnt(24);
        checkOutput("turbo0 owner B", 32'(owner), 4);
        checkOutput("turbo0 ram_a", 32'(ram_a), 32'h78);
        applyIdle();

        repeat (2) @(negedge clk32);
        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule
